// File: rtl/store_demux_1to2.sv
// Store router: MEM-stage stores go to data memory (A) or MMIO (B) by address.
// Each destination owns a small valid/ready FIFO so a stall back-pressures the pipe.

module store_demux_fifo #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [63:0]   i_wdata,
    input  logic          i_ready,
    output logic          o_valid,
    output logic          o_full,
    output logic [63:0]   o_head,
    output logic [CW-1:0] o_count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_pop;

    assign o_valid = (r_cnt != '0);
    assign o_full  = (r_cnt == FULL);
    assign o_count = r_cnt;
    assign o_head  = o_valid ? r_mem[r_rp] : '0;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_wdata;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            unique case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

module store_demux_1to2 #(
    parameter logic [31:0] IO_BASE = 32'hFFFF0000,
    parameter int          DEPTH   = 2,
    localparam int         CW      = $clog2(DEPTH) + 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_addr,
    input  logic [31:0]   in_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [31:0]   a_addr,
    output logic [31:0]   a_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [31:0]   b_addr,
    output logic [31:0]   b_data,
    output logic          busy,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    logic        w_sel;
    logic        w_a_full;
    logic        w_b_full;
    logic        w_push_a;
    logic        w_push_b;
    logic [63:0] w_wdata;
    logic [63:0] w_a_head;
    logic [63:0] w_b_head;

    // Ready looks only at occupancy, so a full FIFO never passes through.
    assign w_sel    = (in_addr >= IO_BASE);
    assign in_ready = w_sel ? !w_b_full : !w_a_full;
    assign w_push_a = in_valid && in_ready && !w_sel;
    assign w_push_b = in_valid && in_ready && w_sel;
    assign w_wdata  = {in_addr, in_data};

    store_demux_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_push  (w_push_a),
        .i_wdata (w_wdata),
        .i_ready (a_ready),
        .o_valid (a_valid),
        .o_full  (w_a_full),
        .o_head  (w_a_head),
        .o_count (a_count)
    );

    store_demux_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .i_clk   (Clk),
        .i_rst_n (Rst_n),
        .i_push  (w_push_b),
        .i_wdata (w_wdata),
        .i_ready (b_ready),
        .o_valid (b_valid),
        .o_full  (w_b_full),
        .o_head  (w_b_head),
        .o_count (b_count)
    );

    assign a_addr = w_a_head[63:32];
    assign a_data = w_a_head[31:0];
    assign b_addr = w_b_head[63:32];
    assign b_data = w_b_head[31:0];
    assign busy   = a_valid || b_valid;

endmodule

// File: tb/tb_store_demux_1to2.sv
// Bench for store_demux_1to2: queue-based model of both destination FIFOs,
// with a negedge monitor comparing every output against it.

module tb_store_demux_1to2;

    localparam logic [31:0] IO_BASE = 32'hFFFF0000;
    localparam int          DEPTH   = 2;
    localparam int          CW      = $clog2(DEPTH) + 1;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_addr;
    logic [31:0]   in_data;
    logic          a_valid;
    logic          a_ready;
    logic [31:0]   a_addr;
    logic [31:0]   a_data;
    logic          b_valid;
    logic          b_ready;
    logic [31:0]   b_addr;
    logic [31:0]   b_data;
    logic          busy;
    logic [CW-1:0] a_count;
    logic [CW-1:0] b_count;

    store_demux_1to2 #(.IO_BASE(IO_BASE), .DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .busy     (busy),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    always #5 Clk = ~Clk;

    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    int  mA = 0, mB = 0, nA = 0, nB = 0;
    bit  exp_ready = 1'b1;
    bit  flush = 1'b0;
    bit  chk_en = 1'b0;
    int  passed = 0;
    int  total = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(exp_ready));
            chk("a_count", 64'(a_count), 64'(mA));
            chk("b_count", 64'(b_count), 64'(mB));
            chk("a_valid", 64'(a_valid), 64'(mA != 0));
            chk("b_valid", 64'(b_valid), 64'(mB != 0));
            chk("busy", 64'(busy), 64'((mA + mB) != 0));
            if (!a_valid) begin
                chk("a_idle", {a_addr, a_data}, 64'd0);
            end else if (exp_a.size() == 0) begin
                chk("a_stale", {a_addr, a_data}, 64'd0);
            end else begin
                chk("a_head", {a_addr, a_data}, exp_a[0]);
                if (a_ready) void'(exp_a.pop_front());
            end
            if (!b_valid) begin
                chk("b_idle", {b_addr, b_data}, 64'd0);
            end else if (exp_b.size() == 0) begin
                chk("b_stale", {b_addr, b_data}, 64'd0);
            end else begin
                chk("b_head", {b_addr, b_data}, exp_b[0]);
                if (b_ready) void'(exp_b.pop_front());
            end
        end
    end

    // One cycle of stimulus; the model state advances for the coming edge.
    task automatic step(input bit v, input logic [31:0] ad, input logic [31:0] dt,
                        input bit ar, input bit br, input bit rn, output bit acc);
        bit sel;
        @(posedge Clk);
        #1;
        if (flush) begin
            exp_a.delete();
            exp_b.delete();
            flush = 1'b0;
        end
        mA = nA;
        mB = nB;
        Rst_n    = rn;
        in_valid = v;
        in_addr  = ad;
        in_data  = dt;
        a_ready  = ar;
        b_ready  = br;
        sel = (ad >= IO_BASE);
        exp_ready = ((sel ? mB : mA) < DEPTH);
        acc = 1'b0;
        if (!rn) begin
            nA = 0;
            nB = 0;
            flush = 1'b1;
        end else begin
            nA = mA - ((ar && mA > 0) ? 1 : 0);
            nB = mB - ((br && mB > 0) ? 1 : 0);
            if (v && exp_ready) begin
                acc = 1'b1;
                if (sel) begin
                    exp_b.push_back({ad, dt});
                    nB++;
                end else begin
                    exp_a.push_back({ad, dt});
                    nA++;
                end
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        unique case ($urandom_range(0, 3))
            0: return IO_BASE | 32'($urandom_range(0, 65535));
            1: return $urandom_range(0, 1) ? IO_BASE : IO_BASE - 32'd1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bit acc;
        int tries;
        Rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        step(0, 0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, acc);
        chk_en = 1'b1;
        step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 1, acc);
        step(1, 32'hFFFF_0000, 32'h1, 0, 0, 1, acc);
        step(1, 32'hFFFE_FFFC, 32'h2, 0, 0, 1, acc);
        repeat (3) step(0, 0, 0, 1, 1, 1, acc);
        step(1, 32'h100, 32'hA1, 0, 0, 1, acc);
        step(1, 32'h104, 32'hA2, 0, 0, 1, acc);
        step(1, 32'h108, 32'hA3, 0, 0, 1, acc);
        chk("a3_refused", 64'(acc), 64'd0);
        step(1, 32'hFFFF_0100, 32'hB1, 0, 0, 1, acc);
        chk("b_accept_while_a_full", 64'(acc), 64'd1);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            step(1, 32'h108, 32'hA3, 1, 0, 1, acc);
            tries++;
        end
        chk("a3_retry_cycles", 64'(tries), 64'd2);
        repeat (3) step(0, 0, 0, 1, 1, 1, acc);
        step(1, 32'h200, 32'hC1, 0, 0, 1, acc);
        step(1, 32'h204, 32'hC2, 1, 0, 1, acc);
        step(1, 32'h208, 32'hC3, 0, 0, 1, acc);
        step(1, 32'h20C, 32'hC4, 1, 0, 1, acc);
        chk("full_no_passthru", 64'(acc), 64'd0);
        repeat (3) step(0, 0, 0, 1, 1, 1, acc);
        for (int i = 0; i < 2 * (DEPTH + 2); i++) begin
            step(1, (i % 2) ? (IO_BASE + 32'(4 * i)) : 32'(4 * i),
                 32'h5000 + 32'(i), 1, 1, 1, acc);
        end
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd_addr(), $urandom(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 1, acc);
        end
        repeat (2) step(1, 32'h300, $urandom(), 0, 0, 1, acc);
        repeat (2) step(1, 32'hFFFF_FF00, $urandom(), 0, 0, 1, acc);
        step(0, 0, 0, 1, 0, 0, acc);
        repeat (4) step(0, 0, 0, 1, 1, 1, acc);
        step(1, 32'h400, 32'hE1, 1, 1, 1, acc);
        repeat (3) step(0, 0, 0, 1, 1, 1, acc);
        @(posedge Clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_demux_1to2.md
# store_demux_1to2

Routes a single stream of 32-bit store transactions (address + data) from the MEM stage to one of two buffered destinations: data memory (port A) or the memory-mapped I/O block (port B). The split is decided by address against a fixed I/O base. It is the distributing counterpart of the 2:1 word multiplexers used in the datapath. Each destination has its own small FIFO with a valid/ready handshake, so a stalled destination back-pressures the pipeline without losing stores.

## Interface
- IO_BASE, 32'hFFFF0000, addresses >= IO_BASE (unsigned) route to port B; all others to port A
- DEPTH, 2, entries per destination FIFO (power of two, >= 2)
- Clk  input  1  rising-edge clock
- Rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  store request present
- in_ready  output  1  request accepted this cycle when high with in_valid
- in_addr  input  32  store address
- in_data  input  32  store data
- a_valid / b_valid  output  1  head entry of FIFO A / B is valid
- a_ready / b_ready  input  1  destination consumes the head entry
- a_addr, a_data / b_addr, b_data  output  32 each  head entry of FIFO A / B, 0 when corresponding valid low
- busy  output  1  either FIFO non-empty
- a_count / b_count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- sel = (in_addr >= IO_BASE), unsigned 32-bit compare; combinational.
- in_ready = (sel ? b_count : a_count) < DEPTH; depends only on current occupancy, never on the same-cycle pop (no full-FIFO pass-through).
- Push: in_valid && in_ready at rising edge writes {in_addr, in_data} into the selected FIFO; the other FIFO is untouched.
- Pop: x_valid && x_ready at rising edge removes head of FIFO x. x_ready with x_valid low is ignored.
- Simultaneous push and pop on the same FIFO (not full): count unchanged, order preserved.
- Per-port FIFO order strictly preserved. No ordering guarantee between ports A and B.
- Pointers wrap modulo DEPTH; count saturates at neither end. Push when full and pop when empty cannot occur by construction.
- in_valid low: in_ready still driven per the rule above, and no state change.
- Reset (Rst_n low at a rising edge): both FIFOs flushed. Pointers and counts go to 0, and all stored entries are discarded, including mid-transfer entries.

## Timing
- Reset values (cycle after Rst_n sampled low): a_valid=b_valid=0, a_addr=a_data=b_addr=b_data=0, a_count=b_count=0, busy=0, in_ready=1.
- Latency: entry pushed at edge N is visible at x_valid/x_addr/x_data after edge N; it can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per port per cycle. Port A and port B can each pop in the same cycle.
- x_valid, x_count, busy are functions of registered state only (no combinational path from in_* or x_ready).
- in_ready has a combinational path from in_addr only.

## Test plan
- Reset, then push addr=32'h0000_0010, data=32'hDEAD_BEEF -> a_valid=1 next cycle with matching a_addr/a_data; b_valid=0; a_count=1; busy=1.
- Push addr=32'hFFFF_0000, data=32'h1 (exact boundary) and addr=32'hFFFE_FFFC, data=32'h2 -> first lands on B, second on A.
- Hold a_ready=0, push 3 stores to port A -> first two accepted, in_ready=0 for the third with a_count=2. A store to port B in the same window is still accepted. Raise a_ready -> entries drain in order, and the third is accepted the cycle after a_count drops to 1.
- FIFO A at count 1 with a_ready=1 and a new A push in the same cycle -> a_count stays 1 and the head advances to the new entry in order. Then a_count=2 full with a_ready=1 -> in_ready=0 that cycle (no pass-through).
- Both FIFOs non-empty, a_ready=b_ready=1 for DEPTH+2 cycles with continuous alternating pushes -> pointers wrap, no loss or duplication, and data order matches the push order per port.
- Fill both FIFOs, assert Rst_n=0 for one edge while a_ready=1 -> all outputs at their reset values next cycle. A stale entry never reappears after Rst_n=1.
